lcd_sequencer: RTL

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

---
 rtl/lcd_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lcd_sequencer.sv
// HD44780-style LCD write sequencer: power-up wait, fixed 4-command init, then one user write at a time.
// Optional macro LCD_SEQ_LINE_WRAP_EN: track column/line and insert a DDRAM line-address command every 16 data writes.
module lcd_sequencer #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned CMD_DLY_CYC = 2500,
    parameter int unsigned CLR_DLY_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       wr_enable,
    output logic       reg_sel,
    output logic [7:0] lcd_data,
    input  logic       wr_finish,
    output logic       init_done,
    output logic       busy
);
    localparam logic [2:0] S_PWRUP   = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAITFIN = 3'd2;
    localparam logic [2:0] S_DELAY   = 3'd3;
    localparam logic [2:0] S_IDLE    = 3'd4;

    // A zero-cycle setting still has to spend one cycle in the wait state.
    localparam logic [19:0] PWR_LAST = (POWERUP_CYC == 0) ? 20'd0 : 20'(POWERUP_CYC - 1);
    localparam logic [19:0] CMD_LOAD = (CMD_DLY_CYC == 0) ? 20'd1 : 20'(CMD_DLY_CYC);
    localparam logic [19:0] CLR_LOAD = (CLR_DLY_CYC == 0) ? 20'd1 : 20'(CLR_DLY_CYC);

    logic [2:0]  state;
    logic [19:0] pwr_cnt;
    logic [19:0] dly_cnt;
    logic [2:0]  init_idx;

`ifdef LCD_SEQ_LINE_WRAP_EN
    logic [3:0]  col;
    logic        line;
    logic        ins_pend;
`endif

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    function automatic logic is_clear(input logic rs, input logic [7:0] data);
        is_clear = !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_IDLE) && init_done;
    assign wr_enable = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_PWRUP;
            pwr_cnt   <= 20'd0;
            dly_cnt   <= 20'd0;
            init_idx  <= 3'd0;
            reg_sel   <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
`ifdef LCD_SEQ_LINE_WRAP_EN
            col       <= 4'd0;
            line      <= 1'b0;
            ins_pend  <= 1'b0;
`endif
        end else begin
            case (state)
                S_PWRUP: begin
                    if (pwr_cnt == PWR_LAST) begin
                        state    <= S_ISSUE;
                        init_idx <= 3'd0;
                        lcd_data <= init_byte(2'd0);
                        reg_sel  <= 1'b0;
                    end else begin
                        pwr_cnt <= pwr_cnt + 20'd1;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAITFIN;
                end
                S_WAITFIN: begin
                    if (wr_finish) begin
                        dly_cnt <= is_clear(reg_sel, lcd_data) ? CLR_LOAD : CMD_LOAD;
                        state   <= S_DELAY;
                        if (!init_done) begin
                            init_idx <= init_idx + 3'd1;
                        end
`ifdef LCD_SEQ_LINE_WRAP_EN
                        // Inserted line commands are never clear/home, so they leave col/line alone.
                        if (init_done) begin
                            if (reg_sel) begin
                                col <= col + 4'd1;
                                if (col == 4'd15) begin
                                    ins_pend <= 1'b1;
                                end
                            end else if (is_clear(reg_sel, lcd_data)) begin
                                col  <= 4'd0;
                                line <= 1'b0;
                            end
                        end
`endif
                    end
                end
                S_DELAY: begin
                    if (dly_cnt <= 20'd1) begin
                        if (!init_done && init_idx != 3'd4) begin
                            state    <= S_ISSUE;
                            lcd_data <= init_byte(init_idx[1:0]);
                            reg_sel  <= 1'b0;
                        end
`ifdef LCD_SEQ_LINE_WRAP_EN
                        else if (ins_pend) begin
                            state    <= S_ISSUE;
                            lcd_data <= line ? 8'h80 : 8'hC0;
                            reg_sel  <= 1'b0;
                            line     <= ~line;
                            ins_pend <= 1'b0;
                        end
`endif
                        else begin
                            state     <= S_IDLE;
                            init_done <= 1'b1;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - 20'd1;
                    end
                end
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= S_ISSUE;
                        reg_sel  <= in_rs;
                        lcd_data <= in_data;
                    end
                end
                default: begin
                    state <= S_PWRUP;
                end
            endcase
        end
    end
endmodule
